imem_responder: RTL and testbench

Instruction-memory responder for the multi-cycle CPU. It answers the CPU fetch request (`imem_req_valid_o` / `pc_o`) with `imem_instr_valid_i` / `imem_instr_i` after a fixed, configurable latency. It holds a word-addressed instruction array with a side load port for boot and bench use, and buffers one request that arrives while a fetch is in flight.

---
 rtl/imem_responder_if.sv | 29 ++
 rtl/imem_responder.sv | 122 ++++++++++++
 tb/tb_imem_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch and load bus between the CPU side and the instruction-memory responder.
interface imem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
);
    localparam int IDX_W = $clog2(MEM_SIZE);

    logic                  req_valid_i;
    logic [ADDR_WIDTH-1:0] req_pc_i;
    logic                  instr_valid_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic                  misaligned_o;
    logic                  busy_o;
    logic                  overflow_o;
    logic                  load_en_i;
    logic [IDX_W-1:0]      load_addr_i;
    logic [DATA_WIDTH-1:0] load_data_i;

    modport master (
        output req_valid_i, req_pc_i, load_en_i, load_addr_i, load_data_i,
        input  instr_valid_o, instr_o, misaligned_o, busy_o, overflow_o
    );

    modport slave (
        input  req_valid_i, req_pc_i, load_en_i, load_addr_i, load_data_i,
        output instr_valid_o, instr_o, misaligned_o, busy_o, overflow_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch replies with a one-entry pending slot.
module imem_responder #(
    parameter int    ADDR_WIDTH = 32,
    parameter int    DATA_WIDTH = 32,
    parameter int    MEM_SIZE   = 1024,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = "imem.hex"
) (
    input  logic            clk_i,
    input  logic            rst_i,
    imem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  pend_v;
    logic [IDX_W-1:0]      pend_idx;
    logic                  pend_mis;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_mis;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  rsp_cycle;
    logic                  acc_pend;
    logic                  acc_live;
    logic                  accept;
    logic [IDX_W-1:0]      acc_idx;
    logic                  acc_mis;
    logic [DATA_WIDTH-1:0] acc_word;
    logic                  unused_pc_bits;

    localparam string unused_init_file = INIT_FILE;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] pc);
        return pc[2 +: IDX_W];
    endfunction

    function automatic logic is_mis(input logic [ADDR_WIDTH-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    // Upper PC bits are deliberately ignored so fetches wrap around the array.
    assign unused_pc_bits = ^bus.req_pc_i;

    always_comb begin
        rsp_cycle = (state == WAIT) && (cnt == '0);
        acc_pend  = rsp_cycle && pend_v;
        acc_live  = bus.req_valid_i && ((state == IDLE) || (rsp_cycle && !pend_v));
        accept    = acc_pend || acc_live;
        acc_idx   = acc_pend ? pend_idx : word_idx(bus.req_pc_i);
        acc_mis   = acc_pend ? pend_mis : is_mis(bus.req_pc_i);
        acc_word  = acc_mis ? '0 : mem[acc_idx];
    end

    always_ff @(posedge clk_i) begin
        if (bus.load_en_i) begin
            mem[bus.load_addr_i] <= bus.load_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            cnt               <= '0;
            pend_v            <= 1'b0;
            pend_idx          <= '0;
            pend_mis          <= 1'b0;
            rsp_data          <= '0;
            rsp_mis           <= 1'b0;
            bus.instr_valid_o <= 1'b0;
            bus.instr_o       <= '0;
            bus.misaligned_o  <= 1'b0;
            bus.busy_o        <= 1'b0;
            bus.overflow_o    <= 1'b0;
        end else begin
            bus.instr_valid_o <= 1'b0;
            if (accept) begin
                state      <= WAIT;
                cnt        <= CNT_LOAD;
                rsp_data   <= acc_word;
                rsp_mis    <= acc_mis;
                bus.busy_o <= 1'b1;
                // With a single-cycle latency the reply goes out straight from the accept.
                if (LATENCY == 1) begin
                    bus.instr_valid_o <= 1'b1;
                    bus.instr_o       <= acc_word;
                    bus.misaligned_o  <= acc_mis;
                end
            end else if (rsp_cycle) begin
                state      <= IDLE;
                bus.busy_o <= 1'b0;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    bus.instr_valid_o <= 1'b1;
                    bus.instr_o       <= rsp_data;
                    bus.misaligned_o  <= rsp_mis;
                end
            end

            // A live request arriving as the pending entry drains takes its place.
            if (acc_pend) begin
                pend_v   <= bus.req_valid_i;
                pend_idx <= word_idx(bus.req_pc_i);
                pend_mis <= is_mis(bus.req_pc_i);
            end else if ((state == WAIT) && !rsp_cycle && bus.req_valid_i) begin
                if (!pend_v) begin
                    pend_v   <= 1'b1;
                    pend_idx <= word_idx(bus.req_pc_i);
                    pend_mis <= is_mis(bus.req_pc_i);
                end else begin
                    bus.overflow_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three latencies driven in parallel against a time-based reference model.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        vld_w [3];
    logic [31:0] ins_w [3];
    logic        mis_w [3];
    logic        bsy_w [3];
    logic        ovf_w [3];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024)) bus ();

        assign bus.req_valid_i = req_valid;
        assign bus.req_pc_i    = req_pc;
        assign bus.load_en_i   = load_en;
        assign bus.load_addr_i = load_addr;
        assign bus.load_data_i = load_data;
        assign vld_w[g] = bus.instr_valid_o;
        assign ins_w[g] = bus.instr_o;
        assign mis_w[g] = bus.misaligned_o;
        assign bsy_w[g] = bus.busy_o;
        assign ovf_w[g] = bus.overflow_o;

        imem_responder #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024), .LATENCY(L), .INIT_FILE("imem.hex")
        ) dut (
            .clk_i(clk),
            .rst_i(rst),
            .bus(bus.slave)
        );

        // Reference: a fetch in flight is a scheduled reply time plus a word read at accept.
        int          cyc = 0;
        bit          infl = 1'b0;
        int          rtime = 0;
        logic [31:0] rword = '0;
        bit          rmis = 1'b0;
        bit          pv = 1'b0;
        logic [31:0] ppc = '0;
        bit          ovf = 1'b0;
        logic [31:0] mm [1024];

        initial begin : model
            logic [31:0] apc;
            bit resp_now;
            forever begin
                @(posedge clk);
                if (rst) begin
                    infl = 1'b0;
                    pv   = 1'b0;
                    ovf  = 1'b0;
                end else begin
                    resp_now = infl && (rtime == cyc);
                    apc = '0;
                    if (infl && !resp_now) begin
                        if (req_valid) begin
                            if (!pv) begin
                                pv  = 1'b1;
                                ppc = req_pc;
                            end else begin
                                ovf = 1'b1;
                            end
                        end
                    end else if (pv || req_valid) begin
                        if (pv) begin
                            apc = ppc;
                            pv  = req_valid;
                            ppc = req_pc;
                        end else begin
                            apc = req_pc;
                        end
                        infl  = 1'b1;
                        rtime = cyc + L;
                        rmis  = (apc % 4) != 0;
                        rword = rmis ? 32'h0 : mm[(apc / 4) % 1024];
                    end else begin
                        infl = 1'b0;
                    end
                end
                if (load_en) mm[load_addr] = load_data;
                cyc++;
            end
        end

        initial begin : compare
            bit e_vld;
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    e_vld = infl && (rtime == cyc);
                    chk($sformatf("valid_L%0d", L), 32'(bus.instr_valid_o), 32'(e_vld));
                    chk($sformatf("busy_L%0d", L), 32'(bus.busy_o), 32'(infl));
                    chk($sformatf("overflow_L%0d", L), 32'(bus.overflow_o), 32'(ovf));
                    if (e_vld) begin
                        chk($sformatf("instr_L%0d", L), bus.instr_o, rword);
                        chk($sformatf("misaligned_L%0d", L), 32'(bus.misaligned_o), 32'(rmis));
                    end
                end
            end
        end
    end

    // One call = one cycle of inputs, applied at the negedge of that cycle.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic le,
                       input logic [9:0] la, input logic [31:0] ld, input logic r);
        @(negedge clk);
        req_valid = v;
        req_pc    = pc;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        rst       = r;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic req(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        cyc(1'b0, '0, 1'b1, a, d, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        do_reset();
        idle(1);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", 32'(vld_w[i]), 0);
            chk("reset_instr", ins_w[i], 0);
            chk("reset_misaligned", 32'(mis_w[i]), 0);
            chk("reset_busy", 32'(bsy_w[i]), 0);
            chk("reset_overflow", 32'(ovf_w[i]), 0);
        end

        for (int a = 0; a < 1024; a++) load(10'(a), $urandom);

        // Basic fetch at latency 2.
        load(10'd4, 32'h0000_0013);
        req(32'h10);
        idle(1);
        chk("A_busy_t1", 32'(bsy_w[1]), 1);
        chk("A_valid_t1", 32'(vld_w[1]), 0);
        idle(1);
        chk("A_valid_t2", 32'(vld_w[1]), 1);
        chk("A_instr_t2", ins_w[1], 32'h13);
        chk("A_mis_t2", 32'(mis_w[1]), 0);
        chk("A_busy_t2", 32'(bsy_w[1]), 1);
        idle(1);
        chk("A_busy_t3", 32'(bsy_w[1]), 0);
        idle(4);

        // Back-to-back at latency 1.
        do_reset();
        for (int k = 0; k < 4; k++) load(10'(k), 32'hA0 + 32'(k));
        req(32'h0);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) req(32'(4 * k)); else idle(1);
            chk("B_valid", 32'(vld_w[0]), 1);
            chk("B_instr", ins_w[0], 32'hA0 + 32'(k - 1));
        end
        idle(1);
        chk("B_overflow", 32'(ovf_w[0]), 0);
        chk("B_gap_after", 32'(vld_w[0]), 0);
        idle(4);

        // Overflow at latency 4.
        do_reset();
        req(32'h0);
        req(32'h4);
        req(32'h8);
        chk("C_ovf_t2", 32'(ovf_w[2]), 0);
        for (int k = 3; k <= 12; k++) begin
            idle(1);
            chk("C_ovf", 32'(ovf_w[2]), 1);
            chk("C_valid", 32'(vld_w[2]), (k == 4 || k == 8) ? 1 : 0);
            if (k == 4) chk("C_instr_t4", ins_w[2], 32'hA0);
            if (k == 8) chk("C_instr_t8", ins_w[2], 32'hA1);
        end

        // Misaligned fetch.
        do_reset();
        req(32'h6);
        idle(2);
        chk("D_valid", 32'(vld_w[1]), 1);
        chk("D_instr", ins_w[1], 0);
        chk("D_mis", 32'(mis_w[1]), 1);
        idle(4);

        // Address wrap.
        load(10'd1, 32'h0000_BEEF);
        req(32'h1004);
        idle(2);
        chk("E_valid", 32'(vld_w[1]), 1);
        chk("E_instr", ins_w[1], 32'hBEEF);
        idle(4);

        // Reset with a fetch in flight and one arriving for the pending slot.
        req(32'h10);
        cyc(1'b1, 32'h14, 1'b0, '0, '0, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            idle(1);
            chk("F_no_valid", 32'(vld_w[1]), 0);
            chk("F_busy", 32'(bsy_w[1]), 0);
            chk("F_ovf", 32'(ovf_w[1]), 0);
        end
        req(32'h10);
        idle(2);
        chk("F_after_valid", 32'(vld_w[1]), 1);
        chk("F_after_instr", ins_w[1], 32'h13);
        idle(4);

        // Randomized traffic; the per-instance models check every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 4) == 0),
                10'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 63) == 0));
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
